// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: default widths, starvation
// limit and the port indices used to tag read responses.
package dmem_pkg;

  localparam int DMEM_ADDR_W   = 10;
  localparam int DMEM_DATA_W   = 32;
  localparam int DMEM_MAX_WAIT = 4;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

endpackage

// File: rtl/dmem_prio_sel.sv
// Combinational two-way grant select: port 0 has fixed priority unless the
// starvation guard forces port 1.
module dmem_prio_sel (
  input  logic p0_req,
  input  logic p1_req,
  input  logic force_p1,
  output logic gnt0,
  output logic gnt1
);

  logic force_active;

  // A force with no port-1 request must never stall port 0.
  assign force_active = force_p1 && p1_req;

  assign gnt0 = p0_req && !force_active;
  assign gnt1 = p1_req && (force_active || !p0_req);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the
// loader/debug master (port 1); read data returns one cycle after issue.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;
  logic       force_p1;
  logic       resp_vld;
  logic       resp_port;
  logic       resp_vld_next;
  logic       resp_port_next;

  assign force_p1 = p1_req && (wait_cnt == WAIT_LIMIT);

  dmem_prio_sel u_prio_sel (
    .p0_req   (p0_req),
    .p1_req   (p1_req),
    .force_p1 (force_p1),
    .gnt0     (p0_gnt),
    .gnt1     (p1_gnt)
  );

  // Starvation counter: only counts unbroken runs of denied port-1 requests.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!p1_req || p1_gnt) begin
      wait_cnt_next = 4'd0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_wren  = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_wren  = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_comb begin
    resp_vld_next  = 1'b0;
    resp_port_next = resp_port;
    if (p0_gnt && !p0_we) begin
      resp_vld_next  = 1'b1;
      resp_port_next = PORT_P0;
    end else if (p1_gnt && !p1_we) begin
      resp_vld_next  = 1'b1;
      resp_port_next = PORT_P1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      resp_vld  <= 1'b0;
      resp_port <= PORT_P0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      resp_vld  <= resp_vld_next;
      resp_port <= resp_port_next;
    end
  end

  // Memory output is held across write cycles, so routing needs no capture.
  assign p0_rvalid = resp_vld && (resp_port == PORT_P0);
  assign p1_rvalid = resp_vld && (resp_port == PORT_P1);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read
// responses per port, a monitor pops and compares them as rvalid appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [9:0]  p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [9:0]  p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wren;
  logic [31:0] p0_rdata, p1_rdata, mem_wdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;

  typedef struct { logic [31:0] data; int due; } resp_t;
  resp_t q0[$];
  resp_t q1[$];

  logic [31:0] mem [1024];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port memory: write at the edge, otherwise register a read; the
  // output holds on write cycles.
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    else          mem_rdata     <= mem[mem_addr];
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic push(input int port, input logic [31:0] data);
    resp_t e;
    e.data = data;
    e.due  = cyc + 1;
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (q0.size() > 0 && q0[0].due < cyc) begin
          e = q0.pop_front();
          chk("p0_missing_rvalid", 32'd0, 32'd1);
        end
        if (q1.size() > 0 && q1[0].due < cyc) begin
          e = q1.pop_front();
          chk("p1_missing_rvalid", 32'd0, 32'd1);
        end
        if (p0_rvalid) begin
          $display("resp p0 data=%h cyc=%0d", p0_rdata, cyc);
          if (q0.size() == 0) chk("p0_unexpected_rvalid", 32'd1, 32'd0);
          else begin
            e = q0.pop_front();
            chk("p0_rdata", p0_rdata, e.data);
            chk("p0_latency", cyc, e.due);
          end
        end else if (p0_rdata !== 32'd0) chk("p0_rdata_idle", p0_rdata, 32'd0);
        if (p1_rvalid) begin
          $display("resp p1 data=%h cyc=%0d", p1_rdata, cyc);
          if (q1.size() == 0) chk("p1_unexpected_rvalid", 32'd1, 32'd0);
          else begin
            e = q1.pop_front();
            chk("p1_rdata", p1_rdata, e.data);
            chk("p1_latency", cyc, e.due);
          end
        end else if (p1_rdata !== 32'd0) chk("p1_rdata_idle", p1_rdata, 32'd0);
      end
    end
  endtask

  task automatic stimulus();
    int idx;
    logic g1;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wait_cnt", dut.wait_cnt, 0);
    reset = 1'b0;

    // Reset while a p0 read response is pending and wait_cnt is nonzero
    set_in(1, 0, 10'd20, 0, 1, 0, 10'd100, 0);
    @(negedge clk);
    chk("rstmid_p0_gnt", p0_gnt, 1);
    chk("rstmid_p1_gnt", p1_gnt, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, 10'd100, 0);
    chk("rstmid_p0_rvalid_pre", p0_rvalid, 1);
    chk("rstmid_wait_pre", dut.wait_cnt, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_p0_rvalid", p0_rvalid, 0);
    chk("rstmid_p0_rdata", p0_rdata, 0);
    chk("rstmid_wait_cnt", dut.wait_cnt, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();

    // Priority with starvation guard
    idx = 0;
    for (int c = 0; c < 11; c++) begin
      g1 = (c == 4);
      set_in(1, 0, 10'(idx), 0, c <= 4, 0, 10'd100, 0);
      if (g1) push(1, 32'hA000_0064);
      else    push(0, 32'hA000_0000 | idx);
      @(negedge clk);
      $display("prio c=%0d gnt0=%b gnt1=%b addr=%0d", c, p0_gnt, p1_gnt, mem_addr);
      chk("prio_gnt0", p0_gnt, !g1);
      chk("prio_gnt1", p1_gnt, g1);
      chk("prio_mem_addr", mem_addr, g1 ? 32'd100 : idx);
      if (!g1) idx++;
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Single port: p1 write then read back
    set_in(0, 0, 0, 0, 1, 1, 10'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("p1_wr_gnt", p1_gnt, 1);
    chk("p1_wr_wren", mem_wren, 1);
    chk("p1_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, 10'd5, 0);
    push(1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("p1_rd_gnt", p1_gnt, 1);
    chk("p1_rd_wren", mem_wren, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Back-to-back: write, read-after-write, p1 read overlapping the response
    set_in(1, 1, 10'd3, 32'h11, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_wr_gnt", p0_gnt, 1);
    chk("b2b_wr_wren", mem_wren, 1);
    next_cycle();
    set_in(1, 0, 10'd3, 0, 0, 0, 0, 0);
    push(0, 32'h11);
    @(negedge clk);
    chk("b2b_rd_gnt", p0_gnt, 1);
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, 10'd7, 0);
    push(1, 32'hA000_0007);
    @(negedge clk);
    chk("b2b_p1_gnt", p1_gnt, 1);
    chk("b2b_p1_addr", mem_addr, 7);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Idle
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_wren", mem_wren, 0);
      chk("idle_gnt", {p0_gnt, p1_gnt}, 0);
      chk("idle_rvalid", {p0_rvalid, p1_rvalid}, 0);
      chk("idle_addr", mem_addr, 0);
      next_cycle();
    end

    // Withdraw: p1 denied 3 cycles, drops req, re-requests
    for (int c = 0; c < 9; c++) begin
      g1 = (c == 8);
      set_in(1, 0, 10'd50, 0, c != 3, 0, 10'd60, 0);
      if (g1) push(1, 32'hA000_003C);
      else    push(0, 32'hA000_0032);
      @(negedge clk);
      $display("wdraw c=%0d gnt0=%b gnt1=%b wait=%0d", c, p0_gnt, p1_gnt, dut.wait_cnt);
      chk("wdraw_gnt1", p1_gnt, g1);
      chk("wdraw_gnt0", p0_gnt, !g1);
      if (c == 3) chk("wdraw_wait_peak", dut.wait_cnt, 3);
      if (c == 4) chk("wdraw_wait_restart", dut.wait_cnt, 0);
      if (c == 8) chk("wdraw_wait_force", dut.wait_cnt, 4);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory (`MEMSTAGE`, 1024×32) between two requesters:
  - port 0: pipeline MEM stage (high priority);
  - port 1: loader/debug master (low priority, starvation-protected).
- Issues at most one access per clock.
- Returns read data one cycle after issue, tagged to the issuing port.
- Sits between both masters and the memory's `MEM_WrEn` / `ALU_MEM_Addr` / `MEM_DataIn` / `MEM_DataOut` pins.

## Interface
Parameters:
- `ADDR_W`, 10, memory word-address width.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, consecutive cycles port 1 may be denied before it is force-granted; legal range 1–15.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `p0_req`, `p1_req` in 1: access request; held until granted.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in `ADDR_W`: word address.
- `p0_wdata`, `p1_wdata` in `DATA_W`: write data.
- `p0_gnt`, `p1_gnt` out 1: request accepted this cycle (combinational).
- `p0_rvalid`, `p1_rvalid` out 1: read data valid (registered).
- `p0_rdata`, `p1_rdata` out `DATA_W`: read data.
- `mem_wren` out 1: to `MEM_WrEn`.
- `mem_addr` out `ADDR_W`: to `ALU_MEM_Addr`.
- `mem_wdata` out `DATA_W`: to `MEM_DataIn`.
- `mem_rdata` in `DATA_W`: from `MEM_DataOut`.

## Operation
- **Transfer rule:**
  - A transfer occurs in a cycle where `pX_req && pX_gnt`.
  - Masters keep `req`/`we`/`addr`/`wdata` stable until granted.
- **Arbitration** (combinational, each cycle):
  - Force condition: `p1_req && wait_cnt == MAX_WAIT`. Then grant port 1.
  - Otherwise, if `p0_req`, grant port 0.
  - Otherwise, if `p1_req`, grant port 1.
  - Otherwise, no grant.
- **`wait_cnt`** (4-bit register):
  - Increments when `p1_req && !p1_gnt`, saturating at `MAX_WAIT`.
  - Clears when `p1_gnt` or when `!p1_req`.
- **Memory drive:**
  - Winner's `addr`/`wdata` go to `mem_addr`/`mem_wdata`.
  - `mem_wren = gnt && we` of the winner.
  - With no grant: `mem_wren = 0`, `mem_addr`/`mem_wdata` = 0.
  - A no-grant cycle still triggers a memory read at address 0. This is harmless and is not forwarded to either port.
- **Response tracking:**
  - Registers `resp_vld` and `resp_port` are set on a granted read (`we = 0`).
  - Otherwise `resp_vld` clears.
  - `pX_rvalid = resp_vld && resp_port == X`.
- **Read data routing:**
  - `pX_rdata = mem_rdata` when `pX_rvalid`, else 0.
  - The memory holds `MEM_DataOut` on write cycles, so the data is valid in the cycle after issue regardless of what is issued in that cycle.
- **Writes** produce no response.

## Timing
- **Reset (async):**
  - `wait_cnt` = 0, `resp_vld` = 0, `resp_port` = 0.
  - Hence all `rvalid` = 0 and `rdata` = 0.
  - `gnt`/`mem_*` follow the combinational rules above: both `req` low gives all zero.
- **Latency and throughput:**
  - Grant: 0 cycles, same cycle as `req` when the port wins.
  - Read data: `rvalid` exactly 1 cycle after the granted cycle.
  - Throughput: 1 access/cycle. Back-to-back reads from either or alternating ports are allowed.
- **Read-after-write** to the same address on consecutive grants returns the new data, because the memory writes at edge T and reads at edge T+1.
- **Simultaneous events:**
  - Both ports requesting with `wait_cnt < MAX_WAIT`: port 0 wins, `wait_cnt` increments.
  - Force grant: port 0 is stalled exactly one cycle, then `wait_cnt` = 0.
- **Reset mid-read:** the pending response is dropped; no `rvalid` after reset release.
- **Dropped request:** `p1` dropping `req` before its grant clears `wait_cnt`. This is a protocol violation but must be tolerated.

## Structure
- Shared package `dmem_pkg`:
  - `ADDR_W`, `DATA_W` defaults;
  - port-index constants `PORT_P0 = 0`, `PORT_P1 = 1`;
  - `MAX_WAIT` default.
- One natural sub-module: `dmem_prio_sel`.
  - Combinational grant select.
  - Inputs: `p0_req`, `p1_req`, `force`.
  - Outputs: `gnt0`, `gnt1`.
- The top level holds `wait_cnt`, the response registers and the muxes.

## Test plan
- **Reset:** assert `reset` mid-cycle with `p0` read pending.
  - → `p0_rvalid` = 0 immediately and stays 0 after release.
  - → `wait_cnt` = 0.
- **Single port:**
  - `p1` writes 0xDEADBEEF to addr 5, then reads addr 5 → `p1_gnt` both cycles.
  - `p1_rvalid` = 1 one cycle after the read grant, with `p1_rdata` = 0xDEADBEEF.
  - `p0_rvalid` = 0 throughout.
- **Priority:**
  - Both request continuously: `p0` reads addrs 0..9, `p1` reads addr 100, `MAX_WAIT` = 4.
  - → `p0` granted 4 cycles, `p1` granted on the 5th, then `p0` resumes.
  - → Each `rvalid` is tagged to the correct port.
- **Back-to-back:**
  - `p0` writes 0x11 to addr 3.
  - Next cycle `p0` reads addr 3 → `p0_rdata` = 0x11.
  - In the same cycle as that response, a `p1` read of addr 7 is granted → its response is 1 cycle later.
- **Idle:** no requests for 10 cycles → `mem_wren` = 0, all `gnt`/`rvalid` = 0.
- **Withdraw:**
  - `p1` requests 3 cycles while denied (`wait_cnt` = 3), drops `req` for 1 cycle, then re-requests.
  - → `wait_cnt` restarts from 0; force grant after 4 further denied cycles.
